// File: rtl/mult_pkg.sv
// Shared encodings for the shift-add multiplier controller.
// State codes, datapath mux selects and the default operand width.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic SEL_LOAD   = 1'b0;
    localparam logic SEL_SHIFT  = 1'b1;
    localparam logic PROD_CLEAR = 1'b0;
    localparam logic PROD_ACCUM = 1'b1;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier; wraps to zero after WIDTH-1.
// Terminal-count flag marks the last add/shift iteration.
module mult_iter_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc    = (count_q == CNT_W'(WIDTH - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = tc ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mult_controller.sv
// Sequencer for the shift-add multiplier datapath: load, WIDTH
// add/shift iterations, then a one-cycle done pulse.
module mult_controller
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             b_lsb,
    output logic             a_sel,
    output logic             b_sel,
    output logic             prod_sel,
    output logic             add_sel,
    output logic             shift_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_count
);

    state_e state_q;
    state_e state_d;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort beats start in IDLE and cancels any in-flight operation
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (start && !abort) ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = abort ? ST_IDLE : ST_CALC;
            ST_CALC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_sel        = SEL_SHIFT;
        b_sel        = SEL_SHIFT;
        prod_sel     = PROD_ACCUM;
        add_sel      = 1'b0;
        shift_enable = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_LOAD: begin
                a_sel    = SEL_LOAD;
                b_sel    = SEL_LOAD;
                prod_sel = PROD_CLEAR;
                busy     = 1'b1;
            end
            ST_CALC: begin
                add_sel      = b_lsb;
                shift_enable = 1'b1;
                busy         = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign cnt_clr = (state_q == ST_LOAD) || (busy && abort);
    assign cnt_inc = (state_q == ST_CALC);

    mult_iter_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(iter_count),
        .tc   (cnt_tc)
    );

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: timeline model plus a small datapath model
// that produces b_lsb and the product.
module tb_mult_controller;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          b_lsb;
    logic          a_sel, b_sel, prod_sel, add_sel, shift_enable, busy, done;
    logic [CW-1:0] iter_count;

    logic [31:0]   data_a = '0;
    logic [31:0]   data_b = '0;
    logic [63:0]   ra = '0;
    logic [31:0]   rb = '0;
    logic [63:0]   rp = '0;

    int            n_chk = 0;
    int            n_pass = 0;
    int            m_t = -1;
    int            cyc = 0;
    int            done_cnt = 0;
    bit            chk_on = 0;

    mult_controller #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .b_lsb       (b_lsb),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .prod_sel    (prod_sel),
        .add_sel     (add_sel),
        .shift_enable(shift_enable),
        .busy        (busy),
        .done        (done),
        .iter_count  (iter_count)
    );

    always #5 clk = ~clk;

    // datapath stand-in: A shifts left, B shifts right, P accumulates
    assign b_lsb = rb[0];
    always @(posedge clk) begin
        if (!a_sel) ra <= {32'b0, data_a};
        else if (shift_enable) ra <= ra << 1;
        if (!b_sel) rb <= data_b;
        else if (shift_enable) rb <= rb >> 1;
        if (!prod_sel) rp <= '0;
        else if (add_sel) rp <= rp + ra;
    end

    // model: m_t = cycles since LOAD (0), CALC 1..W, DONE W+1, idle -1
    always @(posedge clk or posedge rst) begin
        cyc <= cyc + 1;
        if (rst) m_t <= -1;
        else if (m_t < 0) begin
            if (start && !abort) m_t <= 0;
        end else if (m_t <= W && abort) m_t <= -1;
        else if (m_t == W + 1) m_t <= -1;
        else m_t <= m_t + 1;
    end

    function automatic logic [12:0] model_out(int t, logic bl);
        if (t == 0) return {7'b0000010, 6'd0};
        if (t >= 1 && t <= W) return {3'b111, bl, 3'b110, 6'(t - 1)};
        return {3'b111, 3'b000, (t == W + 1), 6'd0};
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cycle_outputs",
                  {a_sel, b_sel, prod_sel, add_sel, shift_enable, busy,
                   done, iter_count},
                  model_out(m_t, b_lsb));
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        data_a = a;
        data_b = b;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_p,
                          input logic [31:0] exp_pat);
        int span = 0;
        int busy_n = 0;
        logic [31:0] pat = '0;
        bit got = 0;
        pulse_start(a, b);
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            span++;
            if (busy) busy_n++;
            if (shift_enable) pat[iter_count[4:0]] = add_sel;
            if (done) got = 1;
        end
        check({nm, "_done_seen"}, 64'(got), 64'd1);
        check({nm, "_span"}, 64'(span), 64'd34);
        check({nm, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check({nm, "_add_pattern"}, 64'(pat), 64'(exp_pat));
        check({nm, "_product"}, rp, exp_p);
    endtask

    task automatic wait_iter(input int it, output bit found);
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (shift_enable && iter_count == CW'(it)) found = 1;
        end
    endtask

    initial begin
        int d0;
        int t1;
        int t2;
        int nd;
        bit f;
        #1 rst = 1'b1;
        #2 chk_on = 1;
        check("reset_outs",
              {a_sel, b_sel, prod_sel, add_sel, shift_enable, busy, done},
              7'b1110000);
        check("reset_iter", 64'(iter_count), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op("b5", 32'd3, 32'd5, 64'd15, 32'h0000_0005);
        run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        run_op("b0", 32'd7, 32'd0, 64'd0, 32'h0);

        // abort mid-CALC
        pulse_start(32'd3, 32'd5);
        wait_iter(5, f);
        check("abort_reach_iter5", 64'(f), 64'd1);
        #2 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        check("abort_idle",
              {a_sel, b_sel, prod_sel, shift_enable, busy, iter_count},
              {5'b11100, 6'd0});
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // start and abort together in IDLE
        @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        check("start_abort_idle", {busy, a_sel, b_sel, prod_sel}, 4'b0111);

        // reset mid-CALC
        pulse_start(32'd3, 32'd5);
        wait_iter(10, f);
        check("rst_reach_iter10", 64'(f), 64'd1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1 check("rst_async_outs",
                 {a_sel, b_sel, prod_sel, add_sel, shift_enable, busy,
                  done, iter_count},
                 {7'b1110000, 6'd0});
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        run_op("after_rst", 32'd3, 32'd5, 64'd15, 32'h0000_0005);

        // start held high: one result every W+3 cycles
        data_a = 32'd3;
        data_b = 32'd5;
        @(posedge clk); #1 start = 1'b1;
        nd = 0;
        t1 = 0;
        t2 = 0;
        for (int n = 0; n < 120 && nd < 2; n++) begin
            @(negedge clk);
            if (done) begin
                if (nd == 0) t1 = cyc;
                else t2 = cyc;
                nd++;
            end
        end
        check("held_two_dones", 64'(nd), 64'd2);
        check("held_period", 64'(t2 - t1), 64'd35);
        check("held_product", rp, 64'd15);
        #1 start = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mult_controller.md
Name: mult_controller

Overview:
- Moore FSM (with one Mealy output) that sequences the 32-bit shift-add multiplier datapath. It drives the datapath's a_sel, b_sel, add_sel, prod_sel and Shift_Enable controls, and reads back the datapath's B-operand LSB.
- Offers a start/done handshake to the host. It loads operands, runs WIDTH add/shift iterations, then pulses done. Prod holds the result until the next start.

Parameters:
- WIDTH, 32, operand width = number of add/shift iterations.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  begin multiplication; sampled only in IDLE.
- abort  input  1  synchronous cancel; return to IDLE without done.
- b_lsb  input  1  datapath oB_LSB (LSB of the B mux output).
- a_sel  output 1  0 = load Data_A, 1 = take shifted A.
- b_sel  output 1  0 = load Data_B, 1 = take shifted B.
- prod_sel  output 1  0 = clear product, 1 = take add-mux result.
- add_sel  output 1  1 = product <= product + A, 0 = product held.
- shift_enable  output 1  drives datapath Shift_Enable.
- busy  output 1  high in LOAD and CALC.
- done  output 1  one-cycle pulse in DONE.
- iter_count  output CNT_W  current iteration index, for debug.

Behaviour:
- States: IDLE=0, LOAD=1, CALC=2, DONE=3, held in a 2-bit state register. Async Reset forces IDLE and iter_count=0.
- Reset/IDLE output values: a_sel=1, b_sel=1, prod_sel=1, add_sel=0, shift_enable=0, busy=0, done=0. These values hold datapath contents, so Prod stays stable.
- IDLE: start=1 at a rising edge moves to LOAD; otherwise stay in IDLE.
- LOAD (1 cycle):
  - Outputs: a_sel=0, b_sel=0, prod_sel=0, add_sel=0, shift_enable=0, busy=1.
  - iter_count is cleared to 0.
  - Next state: CALC.
- CALC (exactly WIDTH cycles):
  - Outputs: a_sel=1, b_sel=1, prod_sel=1, shift_enable=1, busy=1.
  - add_sel = b_lsb, combinational and valid the same cycle. This is the only Mealy output; all others decode from state only.
  - iter_count increments every cycle.
  - When iter_count == WIDTH-1 at the edge, move to DONE and wrap iter_count to 0.
- DONE (1 cycle): done=1, busy=0, all other outputs at IDLE values. Next state: IDLE.
- Latency: start sampled at edge k gives LOAD in cycle k+1, CALC in cycles k+2..k+WIDTH+1, and done=1 in cycle k+WIDTH+2. For WIDTH=32, done arrives 34 cycles after the start edge. Back-to-back throughput is one result per WIDTH+3 cycles.
- start while busy or in DONE: ignored, not queued. It must be re-asserted in IDLE.
- abort=1 in LOAD or CALC: next state IDLE, iter_count=0, no done pulse; the datapath product is left partial.
- abort in IDLE or DONE: no effect; DONE still completes its pulse.
- abort and start both high in IDLE: abort wins and the FSM stays in IDLE.
- Reset asserted mid-CALC: outputs take IDLE values immediately (asynchronous), with no done pulse.
- Illegal state encodings are impossible with 2 bits. The default branch goes to IDLE.
- b_lsb is ignored outside CALC.

Decomposition:
- Shared package mult_pkg:
  - State encodings ST_IDLE, ST_LOAD, ST_CALC, ST_DONE.
  - Select encodings SEL_LOAD=0 and SEL_SHIFT=1.
  - Product-mux encodings PROD_CLEAR=0 and PROD_ACCUM=1.
  - Default MULT_WIDTH=32.
- One sub-module, mult_iter_counter: CNT_W-bit counter with clear, increment and a terminal-count flag (count == WIDTH-1). It has async reset on the same Reset.
- Output decode and next-state logic stay in mult_controller.

Test Plan:
- Reset mid-CALC (assert Reset at iteration 10) -> outputs return to IDLE values in the same cycle, iter_count=0, done never pulses; a later start runs a full 34-cycle operation.
- start pulse, b_lsb driven from a model of B=5 (101b) shifting right -> LOAD 1 cycle with a_sel=b_sel=prod_sel=0; CALC add_sel pattern 1,0,1 then 29 zeros; done=1 exactly 34 cycles after the start edge. With the full datapath, Prod=15 for A=3, B=5.
- A=0xFFFFFFFF, B=0xFFFFFFFF with the datapath -> add_sel high in all 32 CALC cycles; Prod=0xFFFFFFFE00000001 at done; busy high for 33 cycles.
- start held high continuously -> operations repeat every 35 cycles (IDLE, LOAD, 32×CALC, DONE); start is ignored during busy/DONE.
- abort asserted at CALC iteration 5 -> next cycle IDLE, busy=0, no done, iter_count=0. A simultaneous start+abort in IDLE keeps the FSM in IDLE.
- B=0 (b_lsb=0 throughout) -> add_sel never asserts, Prod=0 at done, done timing unchanged at 34 cycles.
